// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Byte-addressed MIPS load/store front end for a word-only memory.
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [5:0]  mem_opcode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] c_OP_LB  = 6'b100000;
  localparam logic [5:0] c_OP_LH  = 6'b100001;
  localparam logic [5:0] c_OP_LW  = 6'b100011;
  localparam logic [5:0] c_OP_LBU = 6'b100100;
  localparam logic [5:0] c_OP_LHU = 6'b100101;
  localparam logic [5:0] c_OP_SB  = 6'b101000;
  localparam logic [5:0] c_OP_SH  = 6'b101001;
  localparam logic [5:0] c_OP_SW  = 6'b101011;

  localparam logic [5:0] c_MEM_IDLE  = 6'b000000;
  localparam logic [5:0] c_MEM_READ  = 6'b100011;
  localparam logic [5:0] c_MEM_WRITE = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_op, w_op_nxt;
  logic [1:0]  r_lane, w_lane_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_err, w_err_nxt;
  logic [5:0]  w_mem_opcode_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] w_mem_wdata_nxt;

  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  logic        unused_bits;

  function automatic logic req_is_err(input logic [5:0] op, input logic [1:0] a);
    case (op)
      c_OP_LB, c_OP_LBU, c_OP_SB: req_is_err = 1'b0;
      c_OP_LH, c_OP_LHU, c_OP_SH: req_is_err = a[0];
      c_OP_LW, c_OP_SW:           req_is_err = (a != 2'b00);
      default:                    req_is_err = 1'b1;
    endcase
  endfunction

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_data   = (r_state == S_RESP) ? r_rdata : 32'd0;
  assign resp_err    = (r_state == S_RESP) ? r_err : 1'b0;
  assign unused_bits = &{1'b0, req_addr[31:ADDR_BITS+2]};

  // Lane select and read-modify-write merge, little-endian byte order.
  assign w_shift = {r_lane, 3'b000};
  assign w_byte  = 8'(mem_rdata >> w_shift);
  assign w_half  = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_mask  = (r_op == c_OP_SB) ? (32'h0000_00FF << w_shift)
                                     : (32'h0000_FFFF << {r_lane[1], 4'b0000});
  assign w_ins   = (r_op == c_OP_SB) ? ({24'd0, r_wdata[7:0]} << w_shift)
                                     : ({16'd0, r_wdata} << {r_lane[1], 4'b0000});

  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_lane_nxt       = r_lane;
    w_wdata_nxt      = r_wdata;
    w_rdata_nxt      = r_rdata;
    w_err_nxt        = r_err;
    w_mem_opcode_nxt = c_MEM_IDLE;
    w_mem_addr_nxt   = mem_addr;
    w_mem_wdata_nxt  = mem_wdata;
    case (r_state)
      S_IDLE: begin
        w_rdata_nxt = 32'd0;
        w_err_nxt   = 1'b0;
        if (req_valid) begin
          w_op_nxt       = req_opcode;
          w_lane_nxt     = req_addr[1:0];
          w_wdata_nxt    = req_wdata[15:0];
          w_mem_addr_nxt = {{(32-ADDR_BITS){1'b0}}, req_addr[ADDR_BITS+1:2]};
          if (req_is_err(req_opcode, req_addr[1:0])) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RESP;
          end else if (req_opcode == c_OP_SW) begin
            w_mem_wdata_nxt  = req_wdata;
            w_mem_opcode_nxt = c_MEM_WRITE;
            w_state_nxt      = S_WRITE;
          end else begin
            w_mem_opcode_nxt = c_MEM_READ;
            w_state_nxt      = S_READ;
          end
        end
      end
      S_READ: begin
        case (r_op)
          c_OP_LB:  w_rdata_nxt = {{24{w_byte[7]}}, w_byte};
          c_OP_LBU: w_rdata_nxt = {24'd0, w_byte};
          c_OP_LH:  w_rdata_nxt = {{16{w_half[15]}}, w_half};
          c_OP_LHU: w_rdata_nxt = {16'd0, w_half};
          default:  w_rdata_nxt = mem_rdata;
        endcase
        if (r_op == c_OP_SB || r_op == c_OP_SH) begin
          w_rdata_nxt      = 32'd0;
          w_mem_wdata_nxt  = (mem_rdata & ~w_mask) | (w_ins & w_mask);
          w_mem_opcode_nxt = c_MEM_WRITE;
          w_state_nxt      = S_WRITE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_WRITE: w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 6'd0;
      r_lane     <= 2'd0;
      r_wdata    <= 16'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      mem_opcode <= c_MEM_IDLE;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_lane     <= w_lane_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
      mem_opcode <= w_mem_opcode_nxt;
      mem_addr   <= w_mem_addr_nxt;
      mem_wdata  <= w_mem_wdata_nxt;
    end
  end

endmodule
`default_nettype wire
